// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped console UART.
//   - register offsets within the 16-byte window (addr[3:2])
//   - STATUS bit positions
//   - serializer FSM state encoding (2-bit)
//   - default console base address
//   - helper that assembles the STATUS word
package mmio_uart_tx_pkg;

    localparam logic [31:0] CONSOLE_BASE_ADDR = 32'h0000_1000;

    localparam logic [1:0] OFF_TXDATA  = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_DIVISOR = 2'd2;
    localparam logic [1:0] OFF_TXCOUNT = 2'd3;

    localparam int ST_OVF_BIT   = 9;
    localparam int ST_BUSY_BIT  = 8;
    localparam int ST_FULL_BIT  = 7;
    localparam int ST_EMPTY_BIT = 6;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    // Assemble the STATUS read word; count sits in bits [3:0].
    function automatic logic [31:0] pack_status(
        input logic       ovf,
        input logic       busy,
        input logic       full,
        input logic       empty,
        input logic [3:0] count
    );
        logic [31:0] s;
        s               = 32'd0;
        s[ST_OVF_BIT]   = ovf;
        s[ST_BUSY_BIT]  = busy;
        s[ST_FULL_BIT]  = full;
        s[ST_EMPTY_BIT] = empty;
        s[3:0]          = count;
        return s;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous FIFO with first-word-fall-through read port.
//   clk, rst_n        : clock, asynchronous active-low reset
//   push, push_data   : enqueue request and data
//   pop               : dequeue request (ignored when empty)
//   pop_data          : current head entry
//   full, empty, count: occupancy (count is 0..DEPTH)
//   drop              : push rejected because the FIFO was full and not popping
// A push while full succeeds when a pop happens in the same cycle.
module mmio_uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Occupancy flags and qualified push/pop strobes.
    always_comb begin
        empty     = (count_r == {CW{1'b0}});
        full      = (count_r == CW'(DEPTH));
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
        drop      = push && full && !do_pop_s;
        count     = count_r;
        pop_data  = mem_r[rd_ptr_r];
    end

    // Storage array; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 console transmitter sharing the core data port with data_mem.
//   clk, rst      : clock, asynchronous active-low reset
//   ce, we, addr  : data-port strobe, write enable, byte address
//   data_i        : write data
//   data_o        : combinational read data (0 when not a read of this window)
//   sel_o         : window hit, used to mux read data against data_mem
//   tx_o          : registered serial line, idle high
//   busy_o        : serializer active or bytes still queued
// Window (offset = addr[3:2]): 0 TXDATA, 1 STATUS, 2 DIVISOR, 3 TXCOUNT.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = CONSOLE_BASE_ADDR,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        sel_o,
    output logic        tx_o,
    output logic        busy_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Bus decode
    logic        sel_s;
    logic        wr_s;
    logic [1:0]  off_s;
    logic        push_s;
    logic        addr_unused_s;

    // FIFO interface
    logic          pop_s;
    logic [7:0]    head_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic [CW-1:0] fifo_count_s;
    logic          fifo_drop_s;
    logic [31:0]   count_ext_s;

    // Registers
    logic [15:0] div_r;
    logic [31:0] txcount_r;
    logic        ovf_r;
    tx_state_e   state_r;
    tx_state_e   state_d;
    logic [15:0] baud_r;
    logic [15:0] baud_d;
    logic [2:0]  bit_idx_r;
    logic [2:0]  bit_idx_d;
    logic [7:0]  shift_r;
    logic [7:0]  shift_d;
    logic        tx_r;
    logic        tx_d;
    logic        frame_done_s;
    logic        bit_end_s;

    // Address decode of the 16-byte window; byte lanes and upper data bits are don't-care.
    always_comb begin
        sel_s         = ce && (addr[31:4] == BASE_ADDR[31:4]);
        wr_s          = sel_s && we;
        off_s         = addr[3:2];
        push_s        = wr_s && (off_s == OFF_TXDATA);
        addr_unused_s = ^{addr[1:0], data_i[31:16]};
    end

    mmio_uart_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push      (push_s),
        .push_data (data_i[7:0]),
        .pop       (pop_s),
        .pop_data  (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s),
        .drop      (fifo_drop_s)
    );

    // Software-visible registers: DIVISOR, TXCOUNT, sticky overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_r     <= DEFAULT_DIV;
            txcount_r <= 32'd0;
            ovf_r     <= 1'b0;
        end else begin
            // A zero divisor would never end a bit, so it is clamped to 1.
            if (wr_s && (off_s == OFF_DIVISOR)) begin
                div_r <= (data_i[15:0] == 16'd0) ? 16'd1 : data_i[15:0];
            end else begin
                div_r <= div_r;
            end
            // A clear request wins over a frame completing in the same cycle.
            if (wr_s && (off_s == OFF_TXCOUNT)) begin
                txcount_r <= 32'd0;
            end else if (frame_done_s) begin
                txcount_r <= txcount_r + 32'd1;
            end else begin
                txcount_r <= txcount_r;
            end
            if (wr_s && (off_s == OFF_STATUS)) begin
                ovf_r <= 1'b0;
            end else if (fifo_drop_s) begin
                ovf_r <= 1'b1;
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end

    // Serializer state register and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= TX_IDLE;
            baud_r    <= 16'd0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
            tx_r      <= 1'b1;
        end else begin
            state_r   <= state_d;
            baud_r    <= baud_d;
            bit_idx_r <= bit_idx_d;
            shift_r   <= shift_d;
            tx_r      <= tx_d;
        end
    end

    // Serializer next-state logic; every bit reloads from the live DIVISOR.
    always_comb begin
        state_d      = state_r;
        baud_d       = baud_r;
        bit_idx_d    = bit_idx_r;
        shift_d      = shift_r;
        pop_s        = 1'b0;
        frame_done_s = 1'b0;
        bit_end_s    = (baud_r == 16'd0);
        case (state_r)
            TX_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s     = 1'b1;
                    shift_d   = head_s;
                    baud_d    = div_r - 16'd1;
                    bit_idx_d = 3'd0;
                    state_d   = TX_START;
                end else begin
                    state_d = TX_IDLE;
                end
            end
            TX_START: begin
                if (bit_end_s) begin
                    baud_d  = div_r - 16'd1;
                    state_d = TX_DATA;
                end else begin
                    baud_d = baud_r - 16'd1;
                end
            end
            TX_DATA: begin
                if (bit_end_s) begin
                    baud_d    = div_r - 16'd1;
                    shift_d   = {1'b0, shift_r[7:1]};
                    bit_idx_d = bit_idx_r + 3'd1;
                    if (bit_idx_r == 3'd7) begin
                        state_d = TX_STOP;
                    end else begin
                        state_d = TX_DATA;
                    end
                end else begin
                    baud_d = baud_r - 16'd1;
                end
            end
            TX_STOP: begin
                if (bit_end_s) begin
                    frame_done_s = 1'b1;
                    state_d      = TX_IDLE;
                end else begin
                    baud_d = baud_r - 16'd1;
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase
    end

    // Line level is computed from the next state so tx_o changes on the same edge as the FSM.
    always_comb begin
        case (state_d)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = shift_d[0];
            TX_STOP:  tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
        busy_o = (state_r != TX_IDLE) || !fifo_empty_s;
        tx_o   = tx_r;
    end

    // Read mux; zero whenever this window is not being read.
    always_comb begin
        count_ext_s = 32'(fifo_count_s);
        data_o      = 32'd0;
        sel_o       = sel_s;
        if (sel_s && !we) begin
            case (off_s)
                OFF_TXDATA:  data_o = 32'd0;
                OFF_STATUS:  data_o = pack_status(ovf_r, busy_o, fifo_full_s,
                                                  fifo_empty_s, count_ext_s[3:0]);
                OFF_DIVISOR: data_o = {16'd0, div_r};
                OFF_TXCOUNT: data_o = txcount_r;
                default:     data_o = 32'd0;
            endcase
        end else begin
            data_o = 32'd0;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE    = 32'h0000_1000;
    localparam logic [31:0] A_TX    = BASE + 32'h0;
    localparam logic [31:0] A_ST    = BASE + 32'h4;
    localparam logic [31:0] A_DIV   = BASE + 32'h8;
    localparam logic [31:0] A_CNT   = BASE + 32'hC;

    logic        clk;
    logic        rst;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        sel_o;
    logic        tx_o;
    logic        busy_o;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Line capture, one sample per clock on the falling edge.
    logic cap_en  = 1'b0;
    logic cap_clr = 1'b0;
    logic cap_buf [0:511];
    int   cap_n   = 0;
    logic exp_buf [0:511];
    int   exp_n   = 0;

    mmio_uart_tx dut (
        .clk    (clk),
        .rst    (rst),
        .ce     (ce),
        .we     (we),
        .addr   (addr),
        .data_i (data_i),
        .data_o (data_o),
        .sel_o  (sel_o),
        .tx_o   (tx_o),
        .busy_o (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cap_clr) begin
            cap_n <= 0;
        end else if (cap_en && cap_n < 512) begin
            cap_buf[cap_n] <= tx_o;
            cap_n          <= cap_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        ce = 1'b1; we = 1'b1; addr = a; data_i = d;
        @(posedge clk);
        #1;
        ce = 1'b0; we = 1'b0; addr = 32'd0; data_i = 32'd0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a,
                          input logic [31:0] exp_d, input logic exp_sel);
        logic [31:0] d;
        logic        s;
        @(negedge clk);
        ce = 1'b1; we = 1'b0; addr = a;
        #1;
        d = data_o;
        s = sel_o;
        #1;
        ce = 1'b0; addr = 32'd0;
        chk(tag, d, exp_d);
        chk({tag, "_sel"}, {31'd0, s}, {31'd0, exp_sel});
    endtask

    task automatic cap_reset();
        cap_en  = 1'b0;
        cap_clr = 1'b1;
        @(negedge clk);
        #1;
        cap_clr = 1'b0;
        exp_n   = 0;
    endtask

    task automatic add_level(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            exp_buf[exp_n] = v;
            exp_n++;
        end
    endtask

    // Pop cycle (idle high), start, 8 data bits LSB first, stop.
    task automatic add_frame(input logic [7:0] b, input int div);
        add_level(1'b1, 1);
        add_level(1'b0, div);
        for (int i = 0; i < 8; i++) add_level(b[i], div);
        add_level(1'b1, div);
    endtask

    task automatic cmp_capture(input string tag);
        int guard;
        int bad;
        guard = 0;
        while (cap_n < exp_n && guard < 3000) begin
            @(posedge clk);
            guard++;
        end
        cap_en = 1'b0;
        chk({tag, "_len_reached"}, {31'd0, (cap_n >= exp_n)}, 32'd1);
        bad = 0;
        for (int i = 0; i < exp_n; i++) begin
            if (bad == 0 && cap_buf[i] !== exp_buf[i]) bad = i + 1;
        end
        chk({tag, "_first_bad_sample_plus1"}, 32'(bad), 32'd0);
    endtask

    initial begin
        rst = 1'b0; ce = 1'b0; we = 1'b0; addr = 32'd0; data_i = 32'd0;

        // 1. Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("t1_tx_in_reset", {31'd0, tx_o}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        rd_chk("t1_status", A_ST, 32'h0000_0040, 1'b1);
        rd_chk("t1_divisor", A_DIV, 32'd4, 1'b1);
        rd_chk("t1_txcount", A_CNT, 32'd0, 1'b1);
        chk("t1_tx_idle", {31'd0, tx_o}, 32'd1);
        chk("t1_busy", {31'd0, busy_o}, 32'd0);

        // 2. DIVISOR=2, one byte 0x55
        wr(A_DIV, 32'd2);
        cap_reset();
        add_frame(8'h55, 2);
        add_level(1'b1, 1);
        wr(A_TX, 32'h55);
        cap_en = 1'b1;
        rd_chk("t2_status_pending", A_ST, 32'h0000_0101, 1'b1);
        cmp_capture("t2_frame");
        rd_chk("t2_txcount", A_CNT, 32'd1, 1'b1);
        rd_chk("t2_status_done", A_ST, 32'h0000_0040, 1'b1);

        // 3. DIVISOR=1, nine back-to-back bytes plus one dropped
        wr(A_DIV, 32'd1);
        wr(A_CNT, 32'd0);
        cap_reset();
        for (int i = 0; i < 9; i++) add_frame(8'(i), 1);
        add_level(1'b1, 1);
        wr(A_TX, 32'h00);
        cap_en = 1'b1;
        for (int i = 1; i < 9; i++) wr(A_TX, 32'(i));
        wr(A_TX, 32'h09);
        rd_chk("t3_status_full_ovf", A_ST, 32'h0000_0388, 1'b1);
        cmp_capture("t3_stream");
        rd_chk("t3_txcount", A_CNT, 32'd9, 1'b1);
        rd_chk("t3_status_ovf_kept", A_ST, 32'h0000_0240, 1'b1);
        wr(A_ST, 32'd0);
        rd_chk("t3_status_ovf_clr", A_ST, 32'h0000_0040, 1'b1);

        // 4. DIVISOR=8 frame, DIVISOR=2 written during data bit 3
        wr(A_DIV, 32'd8);
        wr(A_CNT, 32'd0);
        cap_reset();
        add_level(1'b1, 1);
        add_level(1'b0, 8);
        add_level(1'b1, 8); add_level(1'b0, 8); add_level(1'b1, 8); add_level(1'b0, 8);
        add_level(1'b0, 2); add_level(1'b1, 2); add_level(1'b0, 2); add_level(1'b1, 2);
        add_level(1'b1, 2);
        add_level(1'b1, 1);
        wr(A_TX, 32'hA5);
        cap_en = 1'b1;
        repeat (33) @(posedge clk);
        wr(A_DIV, 32'd2);
        cmp_capture("t4_frame");
        rd_chk("t4_txcount", A_CNT, 32'd1, 1'b1);
        rd_chk("t4_divisor", A_DIV, 32'd2, 1'b1);

        // 5. Reset during data bits of 0xFF with another byte queued
        wr(A_CNT, 32'd0);
        wr(A_TX, 32'hFF);
        wr(A_TX, 32'h11);
        repeat (6) @(posedge clk);
        #1;
        chk("t5_busy_before", {31'd0, busy_o}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_tx_in_reset", {31'd0, tx_o}, 32'd1);
        chk("t5_busy_in_reset", {31'd0, busy_o}, 32'd0);
        rd_chk("t5_status_in_reset", A_ST, 32'h0000_0040, 1'b1);
        rd_chk("t5_txcount_in_reset", A_CNT, 32'd0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        rd_chk("t5_divisor_after", A_DIV, 32'd4, 1'b1);
        cap_reset();
        add_frame(8'h3C, 4);
        add_level(1'b1, 1);
        wr(A_TX, 32'h3C);
        cap_en = 1'b1;
        cmp_capture("t5_frame_after_reset");
        rd_chk("t5_txcount_after", A_CNT, 32'd1, 1'b1);

        // 6. Address decode and register edge cases
        rd_chk("t6_outside_read", BASE + 32'h10, 32'd0, 1'b0);
        wr(BASE + 32'h18, 32'd7);
        rd_chk("t6_outside_write_ignored", A_DIV, 32'd4, 1'b1);
        wr(A_DIV, 32'd0);
        rd_chk("t6_div_zero_is_one", A_DIV, 32'd1, 1'b1);
        wr(A_DIV, 32'hFFFF_0009);
        rd_chk("t6_div_low16", A_DIV, 32'd9, 1'b1);
        rd_chk("t6_byte_lane_ignored", BASE + 32'hB, 32'd9, 1'b1);
        rd_chk("t6_txdata_reads0", A_TX, 32'd0, 1'b1);
        wr(A_CNT, 32'hDEAD_BEEF);
        rd_chk("t6_txcount_clear", A_CNT, 32'd0, 1'b1);
        @(negedge clk);
        ce = 1'b0; we = 1'b0; addr = A_DIV;
        #1;
        chk("t6_no_ce_sel", {31'd0, sel_o}, 32'd0);
        chk("t6_no_ce_data", data_o, 32'd0);
        addr = 32'd0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped responder on the core's data port (ce/we/addr/wdata/rdata), shared with `data_mem` through an address decode.
- Core stores bytes into a small TX FIFO.
- An 8N1 serializer drains the FIFO onto a single line at a programmable divisor.
- Gives test programs a console and byte-stream output alongside the existing memory dump.

Parameters:
- BASE_ADDR, 32'h0000_1000, 16-byte aligned base of the register window.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, at least 2.
- DEFAULT_DIV, 16'd4, reset value of DIVISOR (clocks per bit).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ce  in  1  data-port access strobe from core.
- we  in  1  1 = write, 0 = read.
- addr  in  32  byte address from core.
- data_i  in  32  write data from core.
- data_o  out  32  read data to core, combinational.
- sel_o  out  1  combinational: ce && addr[31:4]==BASE_ADDR[31:4]; used to mux rdata against data_mem.
- tx_o  out  1  serial line, idle high, registered.
- busy_o  out  1  serializer not IDLE or FIFO non-empty.

Behaviour:
- Reset (rst=0, asynchronous):
  - tx_o=1, state=IDLE, FIFO empty, DIVISOR=DEFAULT_DIV, TXCOUNT=0, OVF=0, busy_o=0.
  - Reset mid-frame aborts the frame; tx_o returns high immediately.
- Register map, offset = addr[3:2]; addr[1:0] ignored:
  - 0 TXDATA: write pushes data_i[7:0]; reads 0.
  - 1 STATUS: reads {22'b0, OVF[9], busy[8], full[7], empty[6], 2'b0, count[3:0]}; count is 0..FIFO_DEPTH in the low bits. Any write clears OVF.
  - 2 DIVISOR: R/W of low 16 bits; upper bits read 0. A write of 0 stores 1.
  - 3 TXCOUNT: reads frames completed (32-bit, wraps 0xFFFF_FFFF->0); any write clears it.
- Writes commit on the rising clk edge when sel_o && we.
- data_o = register value when sel_o && !we; otherwise 32'h0. Same-cycle read, zero wait states, matching data_mem timing.
- FIFO:
  - Push when full: data dropped, OVF set (sticky).
  - Push and pop in the same cycle while full: both succeed, count unchanged.
  - Push and pop in the same cycle while count=1: both succeed.
  - Pop only from IDLE.
- Serializer FSM, states IDLE, START, DATA, STOP:
  - IDLE: if !empty, pop head into shift register, baud_cnt<=DIVISOR-1, bit_idx<=0, go to START. tx_o=1.
  - START: tx_o=0.
  - DATA: tx_o=shift[0], LSB first. At each bit end, shift right; bit_idx increments; after bit 7, go to STOP.
  - STOP: tx_o=1. At its end, TXCOUNT+1 and go to IDLE.
  - Each bit lasts exactly DIVISOR clocks. baud_cnt counts down and reloads from the current DIVISOR at every bit boundary. A DIVISOR write mid-frame takes effect from the next bit.
  - A frame is 10*DIVISOR cycles, followed by at least 1 IDLE cycle. Back-to-back period = 10*DIVISOR+1 cycles.
- Latency: TXDATA write at edge k into an empty FIFO while IDLE → pop at edge k+1 → tx_o falls after edge k+1.
- Accesses outside the window: sel_o=0, no state change, data_o=0.

Decomposition:
- Shared defines header `mmio_defs.vh`:
  - Register offsets (TXDATA/STATUS/DIVISOR/TXCOUNT).
  - STATUS bit positions.
  - FSM state encodings (2-bit).
  - Console BASE_ADDR.
- One sub-module `sync_fifo`: parameterised width/depth, push/pop/full/empty/count, same-cycle push+pop rules as above, async active-low reset.
- The top holds the decode, registers and FSM.

Test Plan:
1. Reset then read STATUS and DIVISOR → STATUS=0x40 (empty), DIVISOR=4, tx_o=1, busy_o=0.
2. DIVISOR=2, write TXDATA 0x55 → tx_o low 2 clk, then 1,0,1,0,1,0,1,0 each 2 clk, then stop high 2 clk; total 20 clk; TXCOUNT=1.
3. DIVISOR=1, 9 back-to-back TXDATA writes of 0x00..0x08 from IDLE:
   - First byte pops in the cycle after its write, so 8 entries remain and none is dropped.
   - A 10th immediate write 0x09 → dropped, OVF=1, STATUS[7]=1.
   - Output stream 0x00..0x08, each frame 11 cycles apart.
   - Write STATUS → OVF=0.
4. DIVISOR=8, write 0xA5; after 3 bits, write DIVISOR=2 → remaining bits 2 clk each; frame still decodes 0xA5.
5. Drive rst low mid-DATA for byte 0xFF → tx_o=1 and FIFO empty at once; TXCOUNT unchanged. After release, new byte 0x3C transmits cleanly.
6. Address decode:
   - Read addr BASE+0x10 → sel_o=0, data_o=0.
   - Write DIVISOR=0 → reads back 1.
   - Preload TXCOUNT near 0xFFFF_FFFF via repeated clear/count check → wraps to 0.
